// File: rtl/tour_cmd.sv
// Knight's-tour playback: turns each solver move into a vertical then a horizontal
// move command, and passes UART commands straight through when no tour is running.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] VERT      = 3'd1;
  localparam logic [2:0] VERT_HOLD = 3'd2;
  localparam logic [2:0] HORZ      = 3'd3;
  localparam logic [2:0] HORZ_HOLD = 3'd4;

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  logic [2:0] state_reg, state_next;
  logic [4:0] mv_indx_reg, mv_indx_next;

  logic signed [2:0] dx, dy;
  logic [2:0]        abs_dx, abs_dy;
  logic [15:0]       vert_cmd, horz_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mv_indx_reg <= 5'd0;
    end else begin
      state_reg   <= state_next;
      mv_indx_reg <= mv_indx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mv_indx_next = mv_indx_reg;
    case (state_reg)
      IDLE: begin
        if (start_tour) begin
          state_next   = VERT;
          mv_indx_next = 5'd0;
        end
      end
      // clr_cmd_rdy is the only way out of VERT/HORZ, so send_resp there is ignored
      VERT:      if (clr_cmd_rdy) state_next = VERT_HOLD;
      VERT_HOLD: if (send_resp)   state_next = HORZ;
      HORZ:      if (clr_cmd_rdy) state_next = HORZ_HOLD;
      HORZ_HOLD: begin
        if (send_resp) begin
          if (mv_indx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            state_next   = VERT;
            mv_indx_next = mv_indx_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One-hot move to knight offset; anything else decodes as no motion
  always_comb begin
    dx = 3'sd0;
    dy = 3'sd0;
    case (move)
      8'h01: begin dx =  3'sd1; dy =  3'sd2; end
      8'h02: begin dx = -3'sd1; dy =  3'sd2; end
      8'h04: begin dx = -3'sd2; dy =  3'sd1; end
      8'h08: begin dx = -3'sd2; dy = -3'sd1; end
      8'h10: begin dx = -3'sd1; dy = -3'sd2; end
      8'h20: begin dx =  3'sd1; dy = -3'sd2; end
      8'h40: begin dx =  3'sd2; dy = -3'sd1; end
      8'h80: begin dx =  3'sd2; dy =  3'sd1; end
      default: begin dx = 3'sd0; dy = 3'sd0; end
    endcase
  end

  assign abs_dx = dx[2] ? 3'(-dx) : 3'(dx);
  assign abs_dy = dy[2] ? 3'(-dy) : 3'(dy);

  assign vert_cmd = {4'h2, (dy > 3'sd0) ? 8'h00 : 8'h7F, 1'b0, abs_dy};
  assign horz_cmd = {4'h3, (dx > 3'sd0) ? 8'hBF : 8'h3F, 1'b0, abs_dx};

  always_comb begin
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = 8'h5A;
    case (state_reg)
      VERT:      cmd_rdy = 1'b1;
      VERT_HOLD: cmd = vert_cmd;
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      HORZ_HOLD: begin
        cmd  = horz_cmd;
        resp = (mv_indx_reg == LAST_IDX) ? 8'hA5 : 8'h5A;
      end
      default: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = 8'hA5;
      end
    endcase
  end

  assign mv_indx = mv_indx_reg;

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: a solver table feeds moves by mv_indx and
// expected commands are queued as moves are loaded, then popped as cmd_rdy appears.
module tb_tour_cmd;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  int n_vec;
  int n_miss;
  logic [7:0]  moves_mem [32];
  logic [15:0] exp_q [$];
  logic [15:0] e;
  bit          ok;

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Solver memory addressed by the DUT's move index
  always_comb move = moves_mem[mv_indx];

  function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit horiz);
    int ddx, ddy;
    ddx = 0; ddy = 0;
    case (m)
      8'h01: begin ddx =  1; ddy =  2; end
      8'h02: begin ddx = -1; ddy =  2; end
      8'h04: begin ddx = -2; ddy =  1; end
      8'h08: begin ddx = -2; ddy = -1; end
      8'h10: begin ddx = -1; ddy = -2; end
      8'h20: begin ddx =  1; ddy = -2; end
      8'h40: begin ddx =  2; ddy = -1; end
      8'h80: begin ddx =  2; ddy =  1; end
      default: begin ddx = 0; ddy = 0; end
    endcase
    if (horiz)
      return {4'h3, (ddx > 0) ? 8'hBF : 8'h3F, 4'((ddx < 0) ? -ddx : ddx)};
    else
      return {4'h2, (ddy > 0) ? 8'h00 : 8'h7F, 4'((ddy < 0) ? -ddy : ddy)};
  endfunction

  task automatic wait_rdy(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    @(posedge clk); #1 send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_tour = 1'b1;
    @(posedge clk); #1 start_tour = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic run_step();
    bit g;
    wait_rdy(g); pulse_clr(); pulse_send();
    wait_rdy(g); pulse_clr(); pulse_send();
  endtask

  task automatic test_reset();
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    n_vec++; if (mv_indx !== 5'd0) begin n_miss++; $display("FAIL reset_mv_indx: got %0d expected 0", mv_indx); end
    n_vec++; if (resp !== 8'hA5) begin n_miss++; $display("FAIL reset_resp: got %h expected a5", resp); end
    n_vec++; if (cmd !== 16'h1234) begin n_miss++; $display("FAIL reset_cmd: got %h expected 1234", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1) begin n_miss++; $display("FAIL reset_passthru: got rdy=%b clr=%b expected 1 1", cmd_rdy, clr_cmd_rdy_UART); end
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
    @(negedge clk);
    $display("reset: mv_indx=%0d resp=%h cmd=%h", mv_indx, resp, cmd);
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1 cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (cmd !== 16'h2003) begin n_miss++; $display("FAIL pass_cmd: got %h expected 2003", cmd); end
    n_vec++; if (cmd_rdy !== 1'b1) begin n_miss++; $display("FAIL pass_rdy: got %b expected 1", cmd_rdy); end
    n_vec++; if (clr_cmd_rdy_UART !== 1'b1) begin n_miss++; $display("FAIL pass_clr: got %b expected 1", clr_cmd_rdy_UART); end
    n_vec++; if (resp !== 8'hA5) begin n_miss++; $display("FAIL pass_resp: got %h expected a5", resp); end
    $display("passthrough: cmd=%h rdy=%b clr=%b resp=%h", cmd, cmd_rdy, clr_cmd_rdy_UART, resp);
    @(posedge clk); #1 cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_single_move();
    moves_mem[0] = 8'h01; moves_mem[1] = 8'h08; moves_mem[2] = 8'h03;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_cmd(moves_mem[i], 1'b0));
      exp_q.push_back(exp_cmd(moves_mem[i], 1'b1));
    end
    pulse_start();
    wait_rdy(ok);
    n_vec++; if (!ok) begin n_miss++; $display("FAIL single_vrdy: got timeout expected cmd_rdy"); end
    e = exp_q.pop_front();
    n_vec++; if (cmd !== e) begin n_miss++; $display("FAIL single_vcmd: got %h expected %h", cmd, e); end
    n_vec++; if (mv_indx !== 5'd0) begin n_miss++; $display("FAIL single_idx: got %0d expected 0", mv_indx); end
    n_vec++; if (resp !== 8'h5A) begin n_miss++; $display("FAIL single_resp_v: got %h expected 5a", resp); end
    pulse_send();
    @(negedge clk);
    n_vec++; if (cmd_rdy !== 1'b1 || cmd !== e) begin n_miss++; $display("FAIL single_send_ignored: got rdy=%b cmd=%h expected 1 %h", cmd_rdy, cmd, e); end
    pulse_clr();
    @(negedge clk);
    n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL single_rdy_drop: got %b expected 0", cmd_rdy); end
    pulse_send();
    wait_rdy(ok);
    e = exp_q.pop_front();
    n_vec++; if (!ok || cmd !== e) begin n_miss++; $display("FAIL single_hcmd: got %h expected %h", cmd, e); end
    $display("single_move: move=01 horiz cmd=%h", cmd);
    pulse_clr();
    @(negedge clk);
    n_vec++; if (resp !== 8'h5A) begin n_miss++; $display("FAIL single_resp_h: got %h expected 5a", resp); end
    pulse_send();
  endtask

  task automatic test_direction_decode();
    for (int k = 1; k < 3; k++) begin
      wait_rdy(ok);
      e = exp_q.pop_front();
      n_vec++; if (!ok || cmd !== e) begin n_miss++; $display("FAIL dir_vcmd%0d: got %h expected %h", k, cmd, e); end
      n_vec++; if (mv_indx !== 5'(k)) begin n_miss++; $display("FAIL dir_idx%0d: got %0d expected %0d", k, mv_indx, k); end
      // clr_cmd_rdy and send_resp together: must land in the hold state
      @(posedge clk); #1 clr_cmd_rdy = 1'b1; send_resp = 1'b1;
      @(posedge clk); #1 clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      @(negedge clk);
      n_vec++; if (cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL dir_prio%0d: got rdy=%b expected 0", k, cmd_rdy); end
      pulse_send();
      wait_rdy(ok);
      e = exp_q.pop_front();
      n_vec++; if (!ok || cmd !== e) begin n_miss++; $display("FAIL dir_hcmd%0d: got %h expected %h", k, cmd, e); end
      $display("direction: move=%h horiz cmd=%h", moves_mem[k], cmd);
      pulse_clr();
      pulse_send();
    end
    do_reset();
  endtask

  task automatic test_full_tour();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      moves_mem[i] = 8'h01 << $urandom_range(0, 7);
      exp_q.push_back(exp_cmd(moves_mem[i], 1'b0));
      exp_q.push_back(exp_cmd(moves_mem[i], 1'b1));
    end
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      wait_rdy(ok);
      n_vec++; if (!ok || exp_q.size() == 0) begin n_miss++; $display("FAIL tour_vrdy%0d: got timeout expected cmd_rdy", k); end
      e = exp_q.pop_front();
      n_vec++; if (cmd !== e) begin n_miss++; $display("FAIL tour_vcmd%0d: got %h expected %h", k, cmd, e); end
      n_vec++; if (mv_indx !== 5'(k)) begin n_miss++; $display("FAIL tour_idx%0d: got %0d expected %0d", k, mv_indx, k); end
      n_vec++; if (resp !== 8'h5A) begin n_miss++; $display("FAIL tour_resp_v%0d: got %h expected 5a", k, resp); end
      pulse_clr();
      pulse_send();
      wait_rdy(ok);
      e = exp_q.pop_front();
      n_vec++; if (!ok || cmd !== e) begin n_miss++; $display("FAIL tour_hcmd%0d: got %h expected %h", k, cmd, e); end
      pulse_clr();
      @(negedge clk);
      n_vec++; if (resp !== ((k == 23) ? 8'hA5 : 8'h5A)) begin n_miss++; $display("FAIL tour_resp_h%0d: got %h expected %h", k, resp, (k == 23) ? 8'hA5 : 8'h5A); end
      $display("tour step %0d: move=%h cmd=%h resp=%h", k, moves_mem[k], cmd, resp);
      pulse_send();
    end
    @(negedge clk);
    n_vec++; if (mv_indx !== 5'd23) begin n_miss++; $display("FAIL tour_end_idx: got %0d expected 23", mv_indx); end
    n_vec++; if (cmd !== cmd_UART || resp !== 8'hA5) begin n_miss++; $display("FAIL tour_end_idle: got cmd=%h resp=%h expected %h a5", cmd, resp, cmd_UART); end
  endtask

  task automatic test_reset_mid_tour();
    pulse_start();
    for (int k = 0; k < 7; k++) run_step();
    wait_rdy(ok); pulse_clr(); pulse_send();
    wait_rdy(ok); pulse_clr();
    @(negedge clk);
    n_vec++; if (mv_indx !== 5'd7) begin n_miss++; $display("FAIL rst_mid_idx: got %0d expected 7", mv_indx); end
    cmd_UART = 16'hC0DE; clr_cmd_rdy = 1'b1;
    #1;
    n_vec++; if (clr_cmd_rdy_UART !== 1'b0) begin n_miss++; $display("FAIL rst_mid_noack: got %b expected 0", clr_cmd_rdy_UART); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (mv_indx !== 5'd0) begin n_miss++; $display("FAIL rst_mid_async_idx: got %0d expected 0", mv_indx); end
    n_vec++; if (cmd !== 16'hC0DE || clr_cmd_rdy_UART !== 1'b1 || resp !== 8'hA5) begin n_miss++; $display("FAIL rst_mid_passthru: got cmd=%h clr=%b resp=%h expected c0de 1 a5", cmd, clr_cmd_rdy_UART, resp); end
    @(posedge clk); #1 rst_n = 1'b1; clr_cmd_rdy = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++; if (cmd_rdy !== 1'b0 || cmd !== 16'hC0DE) begin n_miss++; $display("FAIL rst_mid_no_resume: got rdy=%b cmd=%h expected 0 c0de", cmd_rdy, cmd); end
    $display("reset mid-tour: mv_indx=%0d cmd=%h rdy=%b", mv_indx, cmd, cmd_rdy);
  endtask

  task automatic test_interference();
    exp_q.delete();
    exp_q.push_back(exp_cmd(moves_mem[2], 1'b1));
    pulse_start();
    run_step(); run_step();
    wait_rdy(ok);
    pulse_clr();
    @(posedge clk); #1 start_tour = 1'b1; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b0) begin n_miss++; $display("FAIL intf_block: got clr=%b rdy=%b expected 0 0", clr_cmd_rdy_UART, cmd_rdy); end
    @(posedge clk); #1 start_tour = 1'b0; clr_cmd_rdy = 1'b0;
    @(negedge clk);
    n_vec++; if (mv_indx !== 5'd2) begin n_miss++; $display("FAIL intf_idx: got %0d expected 2", mv_indx); end
    pulse_send();
    wait_rdy(ok);
    e = exp_q.pop_front();
    n_vec++; if (!ok || cmd !== e) begin n_miss++; $display("FAIL intf_hcmd: got %h expected %h", cmd, e); end
    do_reset();
    @(negedge clk);
    n_vec++; if (cmd_rdy !== 1'b1 || cmd !== 16'hC0DE) begin n_miss++; $display("FAIL intf_not_lost: got rdy=%b cmd=%h expected 1 c0de", cmd_rdy, cmd); end
    $display("interference: mv_indx=%0d cmd_rdy=%b", mv_indx, cmd_rdy);
    @(posedge clk); #1 cmd_rdy_UART = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h0; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    for (int i = 0; i < 32; i++) moves_mem[i] = 8'h00;
    test_reset();
    test_passthrough();
    test_single_move();
    test_direction_decode();
    test_full_tour();
    test_reset_mid_tour();
    test_interference();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24, meaning the number of moves played per tour (mv_indx runs 0..NUM_MOVES-1).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start_tour, input, 1, one-cycle pulse from the command processor that starts tour playback.
REQ-005 SHALL have port move, input, 8, one-hot move from the solver, addressed by mv_indx.
REQ-006 SHALL have port mv_indx, output, 5, index of the solver move currently being played.
REQ-007 SHALL have port cmd_UART, input, 16, command received over UART.
REQ-008 SHALL have port cmd_rdy_UART, input, 1, UART command valid.
REQ-009 SHALL have port clr_cmd_rdy_UART, output, 1, acknowledge returned to the UART.
REQ-010 SHALL have port clr_cmd_rdy, input, 1, command processor acknowledge of cmd.
REQ-011 SHALL have port send_resp, input, 1, command processor pulse when the current command has finished executing.
REQ-012 SHALL have port cmd, output, 16, command to the command processor.
REQ-013 SHALL have port cmd_rdy, output, 1, cmd valid.
REQ-014 SHALL have port resp, output, 8, response byte to the UART.

Function
REQ-015 SHALL implement states IDLE, VERT, VERT_HOLD, HORZ, HORZ_HOLD.
REQ-016 SHALL, in IDLE, pass UART traffic straight through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
REQ-017 SHALL, in any other state, drive clr_cmd_rdy_UART=0 and source cmd/cmd_rdy internally.
REQ-018 SHALL, on start_tour in IDLE, clear mv_indx to 0 and enter VERT on the next edge.
REQ-019 SHALL ignore start_tour in every state other than IDLE.
REQ-020 SHALL decode move into (dx,dy), with +y = north and +x = east: bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
REQ-021 SHALL decode a non-one-hot move as (0,0).
REQ-022 SHALL form the vertical command as cmd[15:12]=4'h2 (move), cmd[11:4]=8'h00 if dy>0 else 8'h7F (south), cmd[3:0]=|dy|.
REQ-023 SHALL form the horizontal command as cmd[15:12]=4'h3 (move with fanfare), cmd[11:4]=8'hBF if dx>0 (east) else 8'h3F (west), cmd[3:0]=|dx|.
REQ-024 SHALL assert cmd_rdy=1 in VERT and HORZ, and hold cmd stable there until clr_cmd_rdy.
REQ-025 SHALL move VERT->VERT_HOLD and HORZ->HORZ_HOLD on clr_cmd_rdy, with cmd_rdy=0 from the next cycle.
REQ-026 SHALL move VERT_HOLD->HORZ on send_resp.
REQ-027 SHALL, on send_resp in HORZ_HOLD with mv_indx<NUM_MOVES-1, increment mv_indx and return to VERT.
REQ-028 SHALL, on send_resp in HORZ_HOLD with mv_indx==NUM_MOVES-1, return to IDLE with mv_indx held.
REQ-029 SHALL drive resp=8'hA5 in IDLE, and in HORZ_HOLD when mv_indx==NUM_MOVES-1.
REQ-030 SHALL drive resp=8'h5A in all other tour states.
REQ-031 SHALL ignore send_resp while in VERT or HORZ.
REQ-032 SHALL give clr_cmd_rdy priority over send_resp when both are asserted in the same cycle in VERT or HORZ.
REQ-033 SHALL ignore cmd_rdy_UART while a tour is in progress; the command is not acknowledged and not lost.

Reset
REQ-034 SHALL, on rst_n low, enter IDLE with mv_indx=0, taking effect asynchronously.
REQ-035 SHALL, during reset, drive outputs to the IDLE pass-through values (cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5).
REQ-036 SHALL abandon any tour in progress on reset and SHALL NOT resume it after rst_n is released.

Verification
REQ-037 Pass-through: IDLE, cmd_UART=16'h2003, cmd_rdy_UART=1, clr_cmd_rdy=1 -> cmd=16'h2003, cmd_rdy=1, clr_cmd_rdy_UART=1, resp=8'hA5.
REQ-038 Single move: start_tour, move=8'h01 -> cmd=16'h2002 (north 2) with cmd_rdy=1; after clr_cmd_rdy and send_resp -> cmd=16'h3BF1 (east 1).
REQ-039 Direction decode: move=8'h08 -> vertical cmd=16'h27F1 and horizontal cmd=16'h33F2; move=8'h03 -> both commands have squares=0.
REQ-040 Full tour: 24 move/ack/send_resp cycles -> mv_indx steps 0..23, resp=8'h5A until the final HORZ_HOLD, then 8'hA5 and return to IDLE.
REQ-041 Reset mid-tour: rst_n low at mv_indx=7 in HORZ_HOLD -> immediate IDLE, mv_indx=0, pass-through restored.
REQ-042 Interference: start_tour and cmd_rdy_UART pulsed during VERT_HOLD -> no restart, clr_cmd_rdy_UART stays 0, mv_indx unchanged.
